// File: rtl/cache_pkg.sv
// -----------------------------------------------------------------------------
// cache_pkg
// Shared types and helpers for the direct-mapped cache controller slice.
//   state_t  : controller FSM states
//   tagBits  : tag width derived from address width and index width
//   line_t   : per-line metadata bundle (valid, dirty, tag)
// The default widths below are the ones the controller and line array use
// unless overridden. line_t is sized from these defaults, so a build that
// overrides the address or index width must update them here as well.
// -----------------------------------------------------------------------------
package cache_pkg;

  localparam int ADDR_W_DEFAULT     = 32;
  localparam int LINE_W_DEFAULT     = 32;
  localparam int INDEX_BITS_DEFAULT = 6;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    COMPARE   = 2'd1,
    WRITEBACK = 2'd2,
    ALLOCATE  = 2'd3
  } state_t;

  // A byte address splits into tag, index and a 2-bit byte offset.
  function automatic int tagBits(input int addressWidth, input int indexBits);
    return addressWidth - indexBits - 2;
  endfunction

  localparam int TAG_BITS = tagBits(ADDR_W_DEFAULT, INDEX_BITS_DEFAULT);

  typedef struct packed {
    logic                valid;
    logic                dirty;
    logic [TAG_BITS-1:0] tag;
  } line_t;

endpackage

// File: rtl/cache_line_array.sv
// -----------------------------------------------------------------------------
// cache_line_array
// Storage for 2**INDEX_BITS cache lines: valid, dirty, tag and one data word
// per line. One combinational read port and one synchronous write port.
// Valid and dirty clear on rst; tag and data are left unreset because they
// are meaningless while valid is low.
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   rdIndex_i                 read line index
//   rdValid_o/rdDirty_o       metadata of the addressed line
//   rdTag_o/rdData_o          tag and data of the addressed line
//   wrEn_i, wrIndex_i         write strobe and line index
//   wrValid_i/wrDirty_i       new metadata
//   wrTag_i/wrData_i          new tag and data
// -----------------------------------------------------------------------------
module cache_line_array
  import cache_pkg::*;
#(
  parameter int INDEX_BITS = INDEX_BITS_DEFAULT,
  parameter int TAG_W      = TAG_BITS,
  parameter int LINE_SIZE  = LINE_W_DEFAULT
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [INDEX_BITS-1:0] rdIndex_i,
  output logic                  rdValid_o,
  output logic                  rdDirty_o,
  output logic [TAG_W-1:0]      rdTag_o,
  output logic [LINE_SIZE-1:0]  rdData_o,
  input  logic                  wrEn_i,
  input  logic [INDEX_BITS-1:0] wrIndex_i,
  input  logic                  wrValid_i,
  input  logic                  wrDirty_i,
  input  logic [TAG_W-1:0]      wrTag_i,
  input  logic [LINE_SIZE-1:0]  wrData_i
);

  localparam int LINES = 1 << INDEX_BITS;

  logic [LINES-1:0]     valid_q;
  logic [LINES-1:0]     dirty_q;
  logic [TAG_W-1:0]     tag_q  [LINES];
  logic [LINE_SIZE-1:0] data_q [LINES];

  // Reset invalidates every line at once; any dirty contents are dropped.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '0;
      dirty_q <= '0;
    end else if (wrEn_i) begin
      valid_q[wrIndex_i] <= wrValid_i;
      dirty_q[wrIndex_i] <= wrDirty_i;
    end
  end

  always_ff @(posedge clk) begin
    if (wrEn_i) begin
      tag_q[wrIndex_i]  <= wrTag_i;
      data_q[wrIndex_i] <= wrData_i;
    end
  end

  assign rdValid_o = valid_q[rdIndex_i];
  assign rdDirty_o = dirty_q[rdIndex_i];
  assign rdTag_o   = tag_q[rdIndex_i];
  assign rdData_o  = data_q[rdIndex_i];

endmodule

// File: rtl/dm_cache_ctrl.sv
// -----------------------------------------------------------------------------
// dm_cache_ctrl
// Direct-mapped, write-back, write-allocate cache controller, one 32-bit word
// per line. Accepts one CPU request at a time, answers hits from the line
// array and runs writeback/allocate transactions on the memory port for
// misses. After every memory transaction the FSM replays the lookup in
// COMPARE, which also guarantees an idle cycle on memReqValid between a
// writeback and the following allocate.
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   cpuReqValid/cpuAddr/cpuWData/cpuWen   CPU request
//   cpuReady                      high while the controller is idle
//   cpuRespValid/cpuRData         one-cycle completion pulse and read data
//   memReqValid/memReqAddress/memReqDataIn/memReqWen   memory request
//   memRespValid/memRespDataOut   memory response
// -----------------------------------------------------------------------------
module dm_cache_ctrl
  import cache_pkg::*;
#(
  parameter int ADDRESS_WIDTH = ADDR_W_DEFAULT,
  parameter int LINE_SIZE     = LINE_W_DEFAULT,
  parameter int INDEX_BITS    = INDEX_BITS_DEFAULT
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     cpuReqValid,
  input  logic [ADDRESS_WIDTH-1:0] cpuAddr,
  input  logic [LINE_SIZE-1:0]     cpuWData,
  input  logic                     cpuWen,
  output logic                     cpuReady,
  output logic                     cpuRespValid,
  output logic [LINE_SIZE-1:0]     cpuRData,
  output logic                     memReqValid,
  output logic [ADDRESS_WIDTH-1:0] memReqAddress,
  output logic [LINE_SIZE-1:0]     memReqDataIn,
  output logic                     memReqWen,
  input  logic                     memRespValid,
  input  logic [LINE_SIZE-1:0]     memRespDataOut
);

  localparam int TAG_W = tagBits(ADDRESS_WIDTH, INDEX_BITS);

  state_t                   state_q;
  logic [ADDRESS_WIDTH-3:0] reqWord_q;
  logic [LINE_SIZE-1:0]     reqWData_q;
  logic                     reqWen_q;
  logic                     cpuRespValid_q;
  logic [LINE_SIZE-1:0]     cpuRData_q;
  logic                     memReqValid_q;
  logic [ADDRESS_WIDTH-1:0] memReqAddress_q;
  logic [LINE_SIZE-1:0]     memReqDataIn_q;
  logic                     memReqWen_q;

  logic [INDEX_BITS-1:0]    reqIndex;
  logic [TAG_W-1:0]         reqTag;
  logic                     rdValid;
  logic                     rdDirty;
  logic [TAG_W-1:0]         rdTag;
  logic [LINE_SIZE-1:0]     rdData;
  line_t                    rdLine;
  line_t                    wrLine;
  logic [LINE_SIZE-1:0]     wrData;
  logic                     wrEn;
  logic                     hit;
  logic                     memAck;
  logic                     unusedAddrBits;

  // The byte offset is never used: every access is a whole word.
  assign unusedAddrBits = ^cpuAddr[1:0];

  assign reqIndex = reqWord_q[INDEX_BITS-1:0];
  assign reqTag   = reqWord_q[ADDRESS_WIDTH-3:INDEX_BITS];

  cache_line_array #(
    .INDEX_BITS (INDEX_BITS),
    .TAG_W      (TAG_W),
    .LINE_SIZE  (LINE_SIZE)
  ) u_lines (
    .clk       (clk),
    .rst       (rst),
    .rdIndex_i (reqIndex),
    .rdValid_o (rdValid),
    .rdDirty_o (rdDirty),
    .rdTag_o   (rdTag),
    .rdData_o  (rdData),
    .wrEn_i    (wrEn),
    .wrIndex_i (reqIndex),
    .wrValid_i (wrLine.valid),
    .wrDirty_i (wrLine.dirty),
    .wrTag_i   (wrLine.tag),
    .wrData_i  (wrData)
  );

  assign rdLine = '{valid: rdValid, dirty: rdDirty, tag: rdTag};
  assign hit    = rdLine.valid && (rdLine.tag == reqTag);

  // A response only counts while a request is outstanding.
  assign memAck = memReqValid_q && memRespValid;

  // Line updates: write-hit merge, dirty clear after writeback, line fill
  // after allocate. Suppressed during reset so the clear wins.
  always_comb begin
    wrEn   = 1'b0;
    wrLine = rdLine;
    wrData = rdData;
    if (!rst) begin
      case (state_q)
        COMPARE: begin
          if (hit && reqWen_q) begin
            wrEn   = 1'b1;
            wrLine = '{valid: 1'b1, dirty: 1'b1, tag: reqTag};
            wrData = reqWData_q;
          end
        end
        WRITEBACK: begin
          if (memAck) begin
            wrEn         = 1'b1;
            wrLine.dirty = 1'b0;
          end
        end
        ALLOCATE: begin
          if (memAck) begin
            wrEn   = 1'b1;
            wrLine = '{valid: 1'b1, dirty: 1'b0, tag: reqTag};
            wrData = memRespDataOut;
          end
        end
        default: ;
      endcase
    end
  end

  // Main FSM with all CPU and memory outputs registered. The memory request
  // fields are loaded once on entry to WRITEBACK/ALLOCATE and then held
  // untouched until the response edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= IDLE;
      reqWord_q       <= '0;
      reqWData_q      <= '0;
      reqWen_q        <= 1'b0;
      cpuRespValid_q  <= 1'b0;
      cpuRData_q      <= '0;
      memReqValid_q   <= 1'b0;
      memReqAddress_q <= '0;
      memReqDataIn_q  <= '0;
      memReqWen_q     <= 1'b0;
    end else begin
      cpuRespValid_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (cpuReqValid) begin
            reqWord_q  <= cpuAddr[ADDRESS_WIDTH-1:2];
            reqWData_q <= cpuWData;
            reqWen_q   <= cpuWen;
            state_q    <= COMPARE;
          end
        end
        COMPARE: begin
          if (hit) begin
            cpuRespValid_q <= 1'b1;
            cpuRData_q     <= reqWen_q ? reqWData_q : rdData;
            state_q        <= IDLE;
          end else if (rdLine.valid && rdLine.dirty) begin
            memReqValid_q   <= 1'b1;
            memReqWen_q     <= 1'b1;
            memReqAddress_q <= {rdLine.tag, reqIndex, 2'b00};
            memReqDataIn_q  <= rdData;
            state_q         <= WRITEBACK;
          end else begin
            memReqValid_q   <= 1'b1;
            memReqWen_q     <= 1'b0;
            memReqAddress_q <= {reqTag, reqIndex, 2'b00};
            state_q         <= ALLOCATE;
          end
        end
        WRITEBACK, ALLOCATE: begin
          if (memAck) begin
            memReqValid_q <= 1'b0;
            state_q       <= COMPARE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign cpuReady      = (state_q == IDLE);
  assign cpuRespValid  = cpuRespValid_q;
  assign cpuRData      = cpuRData_q;
  assign memReqValid   = memReqValid_q;
  assign memReqAddress = memReqAddress_q;
  assign memReqDataIn  = memReqDataIn_q;
  assign memReqWen     = memReqWen_q;

endmodule

// File: doc/dm_cache_ctrl.md
Name: dm_cache_ctrl

Overview:
Direct-mapped, write-back, write-allocate cache controller with one 32-bit word per line. It sits between a CPU-side request port and the word-addressed backing memory block. It is the initiator on the memory request/response handshake. It accepts one CPU request at a time, serves hits from internal tag/data arrays, and issues writeback and allocate transactions to memory on misses.

Parameters:
ADDRESS_WIDTH, 32, byte address width on both ports
LINE_SIZE, 32, data width and line width in bits (one word per line)
INDEX_BITS, 6, line index width; the cache holds 2**INDEX_BITS lines

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
cpuReqValid  in  1  CPU request present
cpuAddr  in  ADDRESS_WIDTH  CPU byte address; bits [1:0] are ignored
cpuWData  in  LINE_SIZE  CPU write data
cpuWen  in  1  1 = write, 0 = read
cpuReady  out  1  controller can accept a request
cpuRespValid  out  1  one-cycle pulse when the request completes
cpuRData  out  LINE_SIZE  read data, valid while cpuRespValid=1
memReqValid  out  1  memory request, held until response
memReqAddress  out  ADDRESS_WIDTH  memory byte address, bits [1:0]=0
memReqDataIn  out  LINE_SIZE  writeback data
memReqWen  out  1  1 = writeback, 0 = allocate read
memRespValid  in  1  memory response
memRespDataOut  in  LINE_SIZE  memory read data

Behaviour:
- Address split: index = addr[INDEX_BITS+1:2]; tag = addr[ADDRESS_WIDTH-1:INDEX_BITS+2] (TAG_BITS = ADDRESS_WIDTH-INDEX_BITS-2).
- Per-line state: valid bit, dirty bit, tag, and data. Valid and dirty are registers, cleared on rst. Tag and data are not reset.
- Reset values: cpuRespValid=0, cpuRData=0, memReqValid=0, memReqWen=0, memReqAddress=0, memReqDataIn=0, state=IDLE. cpuReady=1 in the first cycle after reset.
- cpuReady = (state==IDLE). The request is accepted on a clk edge where cpuReqValid & cpuReady. The controller latches addr, wdata and wen at that edge.
- FSM states: IDLE, COMPARE, WRITEBACK, ALLOCATE.
- IDLE: on accept, go to COMPARE.
- COMPARE (lookup uses the latched request):
  - Hit (valid & tag match), read: cpuRData <= data, cpuRespValid <= 1, go to IDLE.
  - Hit, write: data <= wdata, dirty <= 1, cpuRData <= wdata, cpuRespValid <= 1, go to IDLE.
  - Miss on a dirty valid line: go to WRITEBACK.
  - Miss otherwise: go to ALLOCATE.
- WRITEBACK: memReqValid=1, memReqWen=1, memReqAddress={oldTag,index,2'b00}, memReqDataIn=oldData. Wait for memRespValid=1. At that edge: memReqValid <= 0, dirty <= 0, go to COMPARE. The replay then sees a clean miss and proceeds to ALLOCATE.
- ALLOCATE: memReqValid=1, memReqWen=0, memReqAddress={tag,index,2'b00}. Wait for memRespValid=1. At that edge: data <= memRespDataOut, tag <= tag, valid <= 1, dirty <= 0, memReqValid <= 0, go to COMPARE. The replay hits; a write request merges in COMPARE.
- Memory handshake rules:
  - All mem* outputs are registered.
  - Address, data and wen stay stable while memReqValid=1.
  - memReqValid drops on the same edge memRespValid=1 is sampled.
  - memRespValid is expected to drop the following cycle.
  - memReqValid is low for at least one cycle between any two transactions. The COMPARE pass between WRITEBACK and ALLOCATE guarantees this.
  - memRespValid while memReqValid=0 is ignored.
- Latency from accept edge to cpuRespValid:
  - Hit: 2 cycles.
  - Clean miss: 2 cycles + memory latency + 1.
  - Dirty miss: adds writeback latency + 1.
- cpuRespValid is high for exactly one cycle. cpuRData holds its value until the next response.
- A cpuReqValid asserted while cpuReady=0 is not accepted. The CPU holds it until accepted.
- Reset mid-operation: FSM returns to IDLE and memReqValid=0 on the next cycle. Any in-flight memory response is ignored, and all lines become invalid. Dirty data is lost by design.
- A memory response never arrives without a request. Unbounded memory latency is permitted (no timeout).

Decomposition:
- Package cache_pkg: state_t enum (IDLE, COMPARE, WRITEBACK, ALLOCATE), the TAG_BITS expression as a function, and a line_t struct {valid, dirty, tag}.
- One natural sub-module: cache_line_array, holding the valid/dirty/tag/data storage. It has one read port (combinational on index) and one write port, and clears valid/dirty on rst. The FSM stays in dm_cache_ctrl.

Test Plan:
Bench memory model: DELAY=4; word i initialised to i+1; INDEX_BITS=6.
- Cold read of 0x10 -> one ALLOCATE with memReqAddress=0x10, memReqWen=0; cpuRData=0x5; cpuRespValid pulses once.
- Repeat read of 0x10 -> hit; cpuRespValid exactly 2 cycles after accept; memReqValid stays 0; cpuRData=0x5.
- Write 0xDEADBEEF to 0x10, then read 0x10 -> no memory traffic; read returns 0xDEADBEEF.
- Read 0x110 (same index 4, tag 1) -> WRITEBACK (addr 0x10, data 0xDEADBEEF, wen=1); then at least one idle cycle on memReqValid; then ALLOCATE of 0x110; cpuRData=0x45.
- Write 0x1234 to clean-miss 0x20 -> ALLOCATE read of 0x20, then merge; no memory write. A later read of 0x820 evicts the line with a writeback of 0x1234 to 0x20.
- Assert rst during ALLOCATE -> memReqValid=0 and cpuReady=1 the next cycle. A subsequent read of 0x10 misses and allocates again.
